// File: rtl/cnn1d_pkg.sv
// Shared types and defaults for the cnn1d inference datapath.
// Holds the frame sequencer state encoding and its size defaults.
package cnn1d_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_STREAM,
    SEQ_WAIT_RESULT,
    SEQ_REPORT
  } seq_state_t;

  localparam int SEQ_FRAME_LEN_DEFAULT = 1000;
  localparam int SEQ_TIMEOUT_DEFAULT   = 65535;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int seq_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn1d_frame_sequencer.sv
// Gates a sample stream into cnn1d one frame at a time, waits for
// each classification (with timeout) and reports it tagged by frame.
module cnn1d_frame_sequencer
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FRAME_LEN      = SEQ_FRAME_LEN_DEFAULT,
  parameter int CLASS_WIDTH    = 1,
  parameter int FRAME_ID_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [FRAME_ID_WIDTH-1:0] num_frames,
  output logic                      busy,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [DATA_WIDTH-1:0]     src_data,
  output logic                      cnn_valid_in,
  input  logic                      cnn_ready_in,
  output logic [DATA_WIDTH-1:0]     cnn_data_in,
  output logic                      cnn_ready_out,
  input  logic                      cnn_result_valid,
  input  logic [CLASS_WIDTH-1:0]    cnn_condition,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [CLASS_WIDTH-1:0]    res_class,
  output logic [FRAME_ID_WIDTH-1:0] res_frame_id,
  output logic                      res_timeout
);

  localparam int SW = seq_cnt_width(FRAME_LEN);
  localparam int TW = seq_cnt_width(TIMEOUT_CYCLES);
  localparam int FW = FRAME_ID_WIDTH;

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t             state_q, state_d;
  logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [FW-1:0]          frame_id_q, frame_id_d;
  logic [FW-1:0]          num_frames_q, num_frames_d;
  logic [CLASS_WIDTH-1:0] res_class_q, res_class_d;
  logic                   res_timeout_q, res_timeout_d;
  logic                   busy_q, busy_d;

  logic in_stream;
  logic sample_hs;
  logic res_hs;
  logic last_frame;

  // Stream path is purely combinational: no buffering, no latency.
  assign in_stream     = (state_q == SEQ_STREAM);
  assign src_ready     = in_stream & cnn_ready_in;
  assign cnn_valid_in  = in_stream & src_valid;
  assign cnn_data_in   = in_stream ? src_data : '0;
  assign cnn_ready_out = (state_q == SEQ_WAIT_RESULT);
  assign res_valid     = (state_q == SEQ_REPORT);

  assign sample_hs  = cnn_valid_in & cnn_ready_in;
  assign res_hs     = res_valid & res_ready;
  assign last_frame = (num_frames_q != '0) &&
                      (frame_id_q == num_frames_q - FW'(1));

  assign busy         = busy_q;
  assign res_class    = res_class_q;
  assign res_frame_id = frame_id_q;
  assign res_timeout  = res_timeout_q;

  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    timer_d       = timer_q;
    frame_id_d    = frame_id_q;
    num_frames_d  = num_frames_q;
    res_class_d   = res_class_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d       = SEQ_STREAM;
          num_frames_d  = num_frames;
          frame_id_d    = '0;
          sample_cnt_d  = '0;
          timer_d       = '0;
          res_class_d   = '0;
          res_timeout_d = 1'b0;
        end
      end
      SEQ_STREAM: begin
        if (sample_hs) begin
          if (sample_cnt_q == SAMPLE_LAST) begin
            sample_cnt_d = '0;
            timer_d      = '0;
            state_d      = SEQ_WAIT_RESULT;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end
      SEQ_WAIT_RESULT: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the timeout cycle still counts.
        if (cnn_result_valid) begin
          res_class_d   = cnn_condition;
          res_timeout_d = 1'b0;
          timer_d       = '0;
          state_d       = SEQ_REPORT;
        end else if (timer_q == TIMER_LAST) begin
          res_class_d   = '0;
          res_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = SEQ_REPORT;
        end
      end
      SEQ_REPORT: begin
        if (res_hs) begin
          frame_id_d = frame_id_q + FW'(1);
          state_d    = last_frame ? SEQ_IDLE : SEQ_STREAM;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Abort overrides every other event in the same cycle.
    if (abort && (state_q != SEQ_IDLE)) begin
      state_d       = SEQ_IDLE;
      sample_cnt_d  = '0;
      timer_d       = '0;
      frame_id_d    = '0;
      res_class_d   = '0;
      res_timeout_d = 1'b0;
    end

    busy_d = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      sample_cnt_q  <= '0;
      timer_q       <= '0;
      frame_id_q    <= '0;
      num_frames_q  <= '0;
      res_class_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      timer_q       <= timer_d;
      frame_id_q    <= frame_id_d;
      num_frames_q  <= num_frames_d;
      res_class_q   <= res_class_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_cnn1d_frame_sequencer.sv
// Self-checking bench for cnn1d_frame_sequencer: per-frame vector
// table, randomized source/ready traffic and a phase-level model.
module tb_cnn1d_frame_sequencer;

  localparam int DW  = 32;
  localparam int FL  = 8;
  localparam int CW  = 2;
  localparam int FIW = 16;
  localparam int TO  = 20;

  localparam int P_IDLE   = 0;
  localparam int P_STREAM = 1;
  localparam int P_WAIT   = 2;
  localparam int P_REPORT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, abort;
  logic [FIW-1:0] num_frames;
  logic           busy;
  logic           src_valid, src_ready;
  logic [DW-1:0]  src_data;
  logic           cnn_valid_in, cnn_ready_in;
  logic [DW-1:0]  cnn_data_in;
  logic           cnn_ready_out, cnn_result_valid;
  logic [CW-1:0]  cnn_condition;
  logic           res_valid, res_ready;
  logic [CW-1:0]  res_class;
  logic [FIW-1:0] res_frame_id;
  logic           res_timeout;

  always #5 clk = ~clk;

  cnn1d_frame_sequencer #(
    .DATA_WIDTH(DW), .FRAME_LEN(FL), .CLASS_WIDTH(CW),
    .FRAME_ID_WIDTH(FIW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_frames(num_frames), .busy(busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .cnn_valid_in(cnn_valid_in), .cnn_ready_in(cnn_ready_in),
    .cnn_data_in(cnn_data_in), .cnn_ready_out(cnn_ready_out),
    .cnn_result_valid(cnn_result_valid), .cnn_condition(cnn_condition),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_frame_id(res_frame_id), .res_timeout(res_timeout)
  );

  // One row per frame: stub result delay (wait-cycle index, -1 = never),
  // condition returned, consumer stall cycles, expected report.
  typedef struct {
    int delay;
    int cond;
    int stall;
    int exp_class;
    int exp_to;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  int ph, mcnt, mwait, mf, mnf, cd, stall_left, src_cnt;
  int cnn_hs_cnt, reports;
  bit gaps, rnd_rdy;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t cur_vec();
    vec_t d;
    d = '{2, 0, 0, 0, 0};
    if (mf < vecs.size()) return vecs[mf];
    return d;
  endfunction

  task automatic check_outputs();
    vec_t v;
    v = cur_vec();
    chk("busy", 64'(busy), 64'(ph != P_IDLE));
    chk("src_ready", 64'(src_ready),
        64'((ph == P_STREAM) && cnn_ready_in));
    chk("cnn_valid_in", 64'(cnn_valid_in),
        64'((ph == P_STREAM) && src_valid));
    if (ph == P_STREAM) chk("cnn_data_in", 64'(cnn_data_in), 64'(src_data));
    chk("cnn_ready_out", 64'(cnn_ready_out), 64'(ph == P_WAIT));
    chk("res_valid", 64'(res_valid), 64'(ph == P_REPORT));
    if (ph == P_REPORT) begin
      chk("res_class", 64'(res_class), 64'(v.exp_class));
      chk("res_timeout", 64'(res_timeout), 64'(v.exp_to));
      chk("res_frame_id", 64'(res_frame_id), 64'(mf % 65536));
    end
  endtask

  // Advances the phase model using the inputs of the cycle just sampled.
  task automatic model_step();
    vec_t v;
    v = cur_vec();
    if (cnn_valid_in && cnn_ready_in) cnn_hs_cnt++;
    if (res_valid && res_ready) reports++;
    if (ph == P_STREAM && src_valid && cnn_ready_in) src_cnt++;
    if (ph != P_IDLE && abort) begin
      ph = P_IDLE; cd = -1; mcnt = 0; mf = 0;
      return;
    end
    case (ph)
      P_IDLE: if (start) begin
        ph = P_STREAM; mnf = int'(num_frames); mf = 0; mcnt = 0;
      end
      P_STREAM: if (src_valid && cnn_ready_in) begin
        mcnt++;
        if (mcnt == FL) begin
          ph = P_WAIT; mcnt = 0; mwait = 0; cd = v.delay;
        end
      end
      P_WAIT: begin
        if (cnn_result_valid || mwait == TO - 1) begin
          ph = P_REPORT; stall_left = v.stall;
        end else begin
          mwait++;
        end
      end
      P_REPORT: if (res_ready) begin
        mf++;
        ph = (mnf != 0 && mf == mnf) ? P_IDLE : P_STREAM;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic tick();
    vec_t v;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    v = cur_vec();
    start = 1'b0;
    abort = 1'b0;
    src_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    src_data = DW'(src_cnt) * 32'h9E37_79B1;
    cnn_ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    cnn_result_valid = (cd == 0);
    cnn_condition = (cd == 0) ? CW'(v.cond) : CW'($urandom);
    if (cd >= 0) cd--;
    if (ph == P_REPORT) begin
      res_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end else begin
      res_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run(input int nf, input int budget);
    num_frames = FIW'(nf);
    start = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ph == P_IDLE) break;
    end
    chk("run_done", 64'(ph == P_IDLE), 64'd1);
  endtask

  initial begin
    bit sent;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_frames = '0;
    src_valid = 1'b1; src_data = '0; cnn_ready_in = 1'b1;
    cnn_result_valid = 1'b0; cnn_condition = '0; res_ready = 1'b0;
    ph = P_IDLE; mcnt = 0; mwait = 0; mf = 0; mnf = 0; cd = -1;
    stall_left = 0; src_cnt = 0; cnn_hs_cnt = 0; reports = 0;
    gaps = 0; rnd_rdy = 0;

    // Reset: everything quiet even with a valid source
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_class", 64'(res_class), 64'd0);
    chk("rst_res_frame_id", 64'(res_frame_id), 64'd0);
    chk("rst_res_timeout", 64'(res_timeout), 64'd0);
    chk("rst_cnn_data_in", 64'(cnn_data_in), 64'd0);
    chk("rst_cnn_ready_out", 64'(cnn_ready_out), 64'd0);
    repeat (3) tick();

    // Two frames, steady traffic
    vecs = '{'{5, 1, 0, 1, 0}, '{5, 0, 0, 0, 0}};
    cnn_hs_cnt = 0; reports = 0;
    run(2, 200);
    repeat (5) tick();
    chk("A_samples", 64'(cnn_hs_cnt), 64'd16);
    chk("A_reports", 64'(reports), 64'd2);

    // Gapped source, random ready, timeout boundaries and stalls
    gaps = 1; rnd_rdy = 1;
    vecs = '{'{19, 3, 3, 3, 0}, '{20, 2, 0, 0, 1},
             '{-1, 1, 10, 0, 1}, '{0, 2, 1, 2, 0},
             '{7, 3, 0, 3, 0}};
    cnn_hs_cnt = 0; reports = 0;
    run(5, 3000);
    repeat (4) tick();
    chk("B_samples", 64'(cnn_hs_cnt), 64'd40);
    chk("B_reports", 64'(reports), 64'd5);

    // Continuous run; stray start ignored; abort at sample 4 of frame 1
    vecs = '{'{3, 2, 0, 2, 0}, '{1, 1, 0, 1, 0}};
    reports = 0; sent = 0;
    num_frames = '0; start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (mf == 1 && ph == P_STREAM && mcnt == 4) break;
      if (mf == 0 && mcnt == 2 && !sent) begin
        start = 1'b1; num_frames = FIW'(1); sent = 1;
      end
    end
    chk("C_reach", 64'(mf == 1 && mcnt == 4), 64'd1);
    abort = 1'b1;
    tick();
    repeat (3) tick();
    chk("C_abort_id", 64'(res_frame_id), 64'd0);
    chk("C_reports", 64'(reports), 64'd1);

    // Abort in the same cycle as the cnn result
    vecs = '{'{3, 1, 0, 1, 0}};
    reports = 0;
    num_frames = '0; start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cnn_result_valid) break;
    end
    chk("D_result_seen", 64'(cnn_result_valid), 64'd1);
    abort = 1'b1;
    repeat (6) tick();
    chk("D_no_report", 64'(reports), 64'd0);

    // Restart after abort begins at frame 0, sample 0
    vecs = '{'{4, 3, 2, 3, 0}, '{20, 1, 0, 0, 1}};
    cnn_hs_cnt = 0;
    run(2, 1000);
    chk("E_samples", 64'(cnn_hs_cnt), 64'd16);

    // Asynchronous reset mid-frame
    vecs = '{'{2, 1, 0, 1, 0}};
    num_frames = '0; start = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("R_busy", 64'(busy), 64'd0);
    chk("R_src_ready", 64'(src_ready), 64'd0);
    chk("R_res_valid", 64'(res_valid), 64'd0);
    ph = P_IDLE; cd = -1; mcnt = 0; mf = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    vecs = '{'{6, 2, 0, 2, 0}};
    run(1, 500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn1d_frame_sequencer.md
Name: cnn1d_frame_sequencer

Overview:
Sequences the cnn1d inference datapath one frame at a time. Gates a raw sample stream into cnn1d in fixed-length frames and waits for each frame's classification, with a timeout. Presents each result, tagged with a frame index, to a downstream consumer. Sits between the sample source (ADC/DMA stream) and cnn1d; a host starts and aborts runs.

Parameters:
DATA_WIDTH, 32, sample width (Q8.24 fixed point; passed through unchanged)
FRAME_LEN, 1000, samples per inference frame
CLASS_WIDTH, 1, width of cnn1d condition output (clog2 NUM_NEURONS)
FRAME_ID_WIDTH, 16, width of frame counter and num_frames
TIMEOUT_CYCLES, 65535, max cycles in WAIT_RESULT before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
abort  in  1  one-cycle pulse; terminates run
num_frames  in  FRAME_ID_WIDTH  frames per run, sampled on start; 0 = continuous
busy  out  1  high in any state except IDLE
src_valid  in  1  sample valid from source
src_ready  out  1  sequencer/cnn ready for sample
src_data  in  DATA_WIDTH  sample
cnn_valid_in  out  1  to cnn1d
cnn_ready_in  in  1  from cnn1d
cnn_data_in  out  DATA_WIDTH  to cnn1d
cnn_ready_out  out  1  to cnn1d, accept result
cnn_result_valid  in  1  cnn1d result strobe
cnn_condition  in  CLASS_WIDTH  cnn1d classification
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_class  out  CLASS_WIDTH  classification
res_frame_id  out  FRAME_ID_WIDTH  frame index, 0-based, wraps at 2^FRAME_ID_WIDTH
res_timeout  out  1  1 = frame timed out, res_class invalid (0)

Behaviour:
- Reset: state IDLE; all counters 0. busy, src_ready, cnn_valid_in, cnn_ready_out, res_valid, res_timeout = 0. res_class, res_frame_id, cnn_data_in = 0.
- States: IDLE, STREAM, WAIT_RESULT, REPORT.
- IDLE: start -> STREAM; latch num_frames; frame_id = 0; sample_cnt = 0.
- STREAM:
  - Combinational pass-through: cnn_valid_in = src_valid; src_ready = cnn_ready_in; cnn_data_in = src_data. No added latency, no buffering.
  - Outside STREAM: src_ready = 0 and cnn_valid_in = 0. Source is back-pressured.
  - sample_cnt increments on each cnn_valid_in & cnn_ready_in.
  - On the handshake with sample_cnt == FRAME_LEN-1: clear sample_cnt, clear timer, go to WAIT_RESULT.
- WAIT_RESULT:
  - cnn_ready_out = 1; timer increments each cycle.
  - cnn_result_valid: register cnn_condition into res_class, res_timeout = 0, go to REPORT.
  - timer == TIMEOUT_CYCLES-1 without a result: res_class = 0, res_timeout = 1, go to REPORT.
  - Result and timeout in the same cycle: the result wins.
- REPORT:
  - res_valid = 1; res_class, res_frame_id, res_timeout held stable until res_valid & res_ready.
  - On that handshake, frame_id increments.
  - If num_frames != 0 and frame_id == num_frames-1: go to IDLE. Otherwise go to STREAM.
  - cnn_ready_out = 0 in REPORT.
- abort, in any non-IDLE state:
  - Next state is IDLE; counters cleared; res_valid dropped even without a handshake.
  - An in-flight sample handshake in the abort cycle completes at the port but is not counted.
  - abort takes precedence over start, frame completion, result and timeout in the same cycle.
- start outside IDLE is ignored.
- Continuous mode: frame_id wraps modulo 2^FRAME_ID_WIDTH and the run never ends without abort.
- Timeouts do not stop the run; the frame is reported and sequencing continues.
- busy is registered from state; it reads 1 from the cycle after start until the cycle after final REPORT handshake or abort.
- Asynchronous reset mid-run forces IDLE immediately. No partial-frame state is retained.

Decomposition:
- cnn1d_pkg gains:
  - typedef enum logic [1:0] seq_state_t {SEQ_IDLE, SEQ_STREAM, SEQ_WAIT_RESULT, SEQ_REPORT}
  - localparam SEQ_FRAME_LEN_DEFAULT = 1000
  - localparam SEQ_TIMEOUT_DEFAULT = 65535
- Single module, no sub-modules. Counters and FSM are small; a separate timer module adds nothing.

Test Plan:
- rst high 3 cycles, then release -> all outputs 0, busy 0, src_ready 0 even with src_valid 1.
- num_frames=2, FRAME_LEN=8, source always valid, cnn_ready_in always 1, cnn_result_valid 5 cycles after last sample with condition 1/0, res_ready 1 -> exactly 16 samples forwarded; results (class 1, id 0, timeout 0) then (class 0, id 1, timeout 0); busy falls; 17th sample not accepted.
- cnn_ready_in toggled randomly and src_valid gapped -> sample_cnt counts only true handshakes; transition to WAIT_RESULT on exactly the 8th handshake; no sample dropped or duplicated.
- TIMEOUT_CYCLES=20, no cnn_result_valid -> REPORT entered on 20th wait cycle with res_timeout=1, res_class=0; next frame starts after handshake.
- res_ready held 0 for 10 cycles in REPORT -> res_valid/res_class/res_frame_id stable; src_ready 0 throughout; frame_id increments only on handshake.
- abort pulsed at sample 4 of frame 1, plus abort coincident with cnn_result_valid -> IDLE next cycle, res_valid 0, no result emitted; a new start restarts at frame_id 0, sample_cnt 0.
